// File: rtl/time_entry.sv
// Time/alarm entry controller.
// Turns five push-button levels into a BCD edit session on either the live
// clock time or a stored alarm time, then commits with a one-cycle strobe.
// Edits are abandoned on cancel, on a second mode press from the alarm target,
// or after TIMEOUT idle cycles.
module time_entry #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_enter,
  input  logic       btn_cancel,
  input  logic [1:0] cur_hour_msb,
  input  logic [3:0] cur_hour_lsb,
  input  logic [3:0] cur_min_msb,
  input  logic [3:0] cur_min_lsb,
  output logic [1:0] inhour_msb,
  output logic [3:0] inhour_lsb,
  output logic [3:0] inmin_msb,
  output logic [3:0] inmin_lsb,
  output logic       set_time,
  output logic       set_alarm,
  output logic       editing,
  output logic       edit_alarm,
  output logic [1:0] edit_digit
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [1:0] hm;
    logic [3:0] hl;
    logic [3:0] mm;
    logic [3:0] ml;
  } bcd_t;

  typedef enum logic [1:0] {IDLE, EDIT_TIME, EDIT_ALARM, COMMIT} state_t;

  // button order in the vectors: {cancel, enter, mode, next, inc}
  logic [4:0] btn, prev, press;
  logic       armed;
  state_t     state;
  bcd_t       ebuf, shadow, cur;
  logic [CW-1:0] cnt;

  assign btn = {btn_cancel, btn_enter, btn_mode, btn_next, btn_inc};
  assign cur = {cur_hour_msb, cur_hour_lsb, cur_min_msb, cur_min_lsb};

  // armed stays low for the first clock after reset so a button already held
  // through reset is only sampled into prev, never seen as a fresh press
  assign press = btn & ~prev & {5{armed}};

  assign {inhour_msb, inhour_lsb, inmin_msb, inmin_lsb} = ebuf;

  // Per-digit increment with no carry; out-of-range inputs wrap to 0.
  function automatic bcd_t bump(input bcd_t b, input logic [1:0] d);
    bcd_t r;
    r = b;
    case (d)
      2'd0: begin
        r.hm = (b.hm >= 2'd2) ? 2'd0 : b.hm + 2'd1;
        if (r.hm == 2'd2 && r.hl > 4'd3) r.hl = 4'd0;
      end
      2'd1: begin
        if (b.hm == 2'd2) r.hl = (b.hl >= 4'd3) ? 4'd0 : b.hl + 4'd1;
        else              r.hl = (b.hl >= 4'd9) ? 4'd0 : b.hl + 4'd1;
      end
      2'd2:    r.mm = (b.mm >= 4'd5) ? 4'd0 : b.mm + 4'd1;
      default: r.ml = (b.ml >= 4'd9) ? 4'd0 : b.ml + 4'd1;
    endcase
    return r;
  endfunction

  // Edit FSM: state, edit buffer, alarm shadow, inactivity counter, strobes.
  // The if/else chain in the edit states encodes cancel > enter > mode > next > inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ebuf       <= '0;
      shadow     <= '0;
      cnt        <= '0;
      prev       <= '0;
      armed      <= 1'b0;
      set_time   <= 1'b0;
      set_alarm  <= 1'b0;
      editing    <= 1'b0;
      edit_alarm <= 1'b0;
      edit_digit <= 2'd0;
    end else begin
      armed     <= 1'b1;
      prev      <= btn;
      set_time  <= 1'b0;
      set_alarm <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press[2]) begin
            state      <= EDIT_TIME;
            editing    <= 1'b1;
            edit_alarm <= 1'b0;
            ebuf       <= cur;
            edit_digit <= 2'd0;
          end
        end
        EDIT_TIME, EDIT_ALARM: begin
          if (press[4]) begin
            state      <= IDLE;
            editing    <= 1'b0;
            edit_alarm <= 1'b0;
            cnt        <= '0;
          end else if (press[3]) begin
            state      <= COMMIT;
            editing    <= 1'b0;
            edit_alarm <= 1'b0;
            cnt        <= '0;
            if (state == EDIT_ALARM) begin
              set_alarm <= 1'b1;
              shadow    <= ebuf;
            end else begin
              set_time  <= 1'b1;
            end
          end else if (press[2]) begin
            cnt <= '0;
            if (state == EDIT_TIME) begin
              state      <= EDIT_ALARM;
              edit_alarm <= 1'b1;
              ebuf       <= shadow;
              edit_digit <= 2'd0;
            end else begin
              state      <= IDLE;
              editing    <= 1'b0;
              edit_alarm <= 1'b0;
            end
          end else if (press[1]) begin
            edit_digit <= edit_digit + 2'd1;
            cnt        <= '0;
          end else if (press[0]) begin
            ebuf <= bump(ebuf, edit_digit);
            cnt  <= '0;
          end else if (cnt >= TLAST) begin
            state      <= IDLE;
            editing    <= 1'b0;
            edit_alarm <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // COMMIT: strobe is visible this cycle, all buttons ignored
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry: time set, alarm set, hour clamp, digit wrap,
// press priority, held buttons, timeout and asynchronous reset.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;  // {cancel, enter, mode, next, inc}
  logic [13:0] cur;
  logic [1:0] inhour_msb;
  logic [3:0] inhour_lsb, inmin_msb, inmin_lsb;
  logic       set_time, set_alarm, editing, edit_alarm;
  logic [1:0] edit_digit;
  logic [13:0] in_t;

  int n_chk = 0;
  int n_fail = 0;

  assign in_t = {inhour_msb, inhour_lsb, inmin_msb, inmin_lsb};

  time_entry #(.TIMEOUT(30)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn[2]), .btn_next(btn[1]), .btn_inc(btn[0]),
    .btn_enter(btn[3]), .btn_cancel(btn[4]),
    .cur_hour_msb(cur[13:12]), .cur_hour_lsb(cur[11:8]),
    .cur_min_msb(cur[7:4]), .cur_min_lsb(cur[3:0]),
    .inhour_msb(inhour_msb), .inhour_lsb(inhour_lsb),
    .inmin_msb(inmin_msb), .inmin_lsb(inmin_lsb),
    .set_time(set_time), .set_alarm(set_alarm),
    .editing(editing), .edit_alarm(edit_alarm), .edit_digit(edit_digit)
  );

  always #5 clk = ~clk;

  // one clean press of button b, n times; returns on a negedge with outputs settled
  task automatic press(input int b, input int n = 1);
    for (int i = 0; i < n; i++) begin
      btn[b] = 1'b1;
      @(negedge clk);
      btn = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; btn = '0; cur = '0;
    #3;
    n_chk++; if (in_t !== 14'd0) begin n_fail++; $display("FAIL reset_in: got %h exp 0", in_t); end
    n_chk++; if ({set_time, set_alarm, editing, edit_alarm} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {set_time, set_alarm, editing, edit_alarm}); end
    n_chk++; if (edit_digit !== 2'd0) begin n_fail++; $display("FAIL reset_digit: got %0d exp 0", edit_digit); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_time_set;
    cur = {2'd1, 4'd1, 4'd2, 4'd6};
    press(2);
    n_chk++; if ({editing, edit_alarm} !== 2'b10) begin n_fail++; $display("FAIL ts_mode_flags: got %b exp 10", {editing, edit_alarm}); end
    n_chk++; if (in_t !== {2'd1, 4'd1, 4'd2, 4'd6}) begin n_fail++; $display("FAIL ts_load: got %h exp 1126", in_t); end
    n_chk++; if (edit_digit !== 2'd0) begin n_fail++; $display("FAIL ts_digit0: got %0d exp 0", edit_digit); end
    press(0);
    n_chk++; if (in_t !== {2'd2, 4'd1, 4'd2, 4'd6}) begin n_fail++; $display("FAIL ts_inc_hm: got %h exp 2126", in_t); end
    press(1);
    n_chk++; if (edit_digit !== 2'd1) begin n_fail++; $display("FAIL ts_next: got %0d exp 1", edit_digit); end
    press(0);
    n_chk++; if (in_t !== {2'd2, 4'd2, 4'd2, 4'd6}) begin n_fail++; $display("FAIL ts_inc_hl: got %h exp 2226", in_t); end
    btn[3] = 1'b1;
    @(negedge clk);
    n_chk++; if ({set_time, set_alarm} !== 2'b10) begin n_fail++; $display("FAIL ts_strobe: got %b exp 10", {set_time, set_alarm}); end
    n_chk++; if (in_t !== {2'd2, 4'd2, 4'd2, 4'd6}) begin n_fail++; $display("FAIL ts_strobe_val: got %h exp 2226", in_t); end
    btn = '0;
    cur = {2'd0, 4'd5, 4'd0, 4'd5};
    @(negedge clk);
    n_chk++; if ({set_time, editing} !== 2'b00) begin n_fail++; $display("FAIL ts_after: got %b exp 00", {set_time, editing}); end
    repeat (3) @(negedge clk);
    n_chk++; if (in_t !== {2'd2, 4'd2, 4'd2, 4'd6}) begin n_fail++; $display("FAIL ts_hold: got %h exp 2226", in_t); end
  endtask

  task automatic test_alarm_set;
    press(2); press(2);
    n_chk++; if ({editing, edit_alarm} !== 2'b11) begin n_fail++; $display("FAIL al_flags: got %b exp 11", {editing, edit_alarm}); end
    n_chk++; if (in_t !== 14'd0) begin n_fail++; $display("FAIL al_load: got %h exp 0000", in_t); end
    press(1, 2);
    n_chk++; if (edit_digit !== 2'd2) begin n_fail++; $display("FAIL al_digit2: got %0d exp 2", edit_digit); end
    press(0, 3); press(1); press(0, 5);
    n_chk++; if (in_t !== {2'd0, 4'd0, 4'd3, 4'd5}) begin n_fail++; $display("FAIL al_value: got %h exp 0035", in_t); end
    btn[3] = 1'b1;
    @(negedge clk);
    n_chk++; if ({set_time, set_alarm} !== 2'b01) begin n_fail++; $display("FAIL al_strobe: got %b exp 01", {set_time, set_alarm}); end
    n_chk++; if (in_t !== {2'd0, 4'd0, 4'd3, 4'd5}) begin n_fail++; $display("FAIL al_strobe_val: got %h exp 0035", in_t); end
    btn = '0;
    @(negedge clk);
    n_chk++; if (set_alarm !== 1'b0) begin n_fail++; $display("FAIL al_one_cycle: got %b exp 0", set_alarm); end
    press(2); press(2);
    n_chk++; if (in_t !== {2'd0, 4'd0, 4'd3, 4'd5}) begin n_fail++; $display("FAIL al_reload: got %h exp 0035", in_t); end
    press(2);
    n_chk++; if ({editing, edit_alarm} !== 2'b00) begin n_fail++; $display("FAIL al_mode_exit: got %b exp 00", {editing, edit_alarm}); end
  endtask

  task automatic test_hour_clamp;
    cur = {2'd1, 4'd9, 4'd0, 4'd0};
    press(2); press(0);
    n_chk++; if (in_t !== {2'd2, 4'd0, 4'd0, 4'd0}) begin n_fail++; $display("FAIL hc_clamp: got %h exp 2000", in_t); end
    press(1); press(0, 3);
    n_chk++; if (in_t !== {2'd2, 4'd3, 4'd0, 4'd0}) begin n_fail++; $display("FAIL hc_23: got %h exp 2300", in_t); end
    press(0);
    n_chk++; if (in_t !== {2'd2, 4'd0, 4'd0, 4'd0}) begin n_fail++; $display("FAIL hc_wrap: got %h exp 2000", in_t); end
    btn[4] = 1'b1;
    @(negedge clk);
    n_chk++; if ({editing, set_time, set_alarm} !== 3'b000) begin n_fail++; $display("FAIL hc_cancel: got %b exp 000", {editing, set_time, set_alarm}); end
    btn = '0;
    @(negedge clk);
    n_chk++; if (in_t !== {2'd2, 4'd0, 4'd0, 4'd0}) begin n_fail++; $display("FAIL hc_keep: got %h exp 2000", in_t); end
  endtask

  task automatic test_wrap;
    cur = {2'd1, 4'd3, 4'd5, 4'd9};
    press(2); press(1, 2); press(0);
    n_chk++; if (in_t !== {2'd1, 4'd3, 4'd0, 4'd9}) begin n_fail++; $display("FAIL wr_mm: got %h exp 1309", in_t); end
    press(1);
    n_chk++; if (edit_digit !== 2'd3) begin n_fail++; $display("FAIL wr_digit3: got %0d exp 3", edit_digit); end
    press(0);
    n_chk++; if (in_t !== {2'd1, 4'd3, 4'd0, 4'd0}) begin n_fail++; $display("FAIL wr_ml: got %h exp 1300", in_t); end
    press(1);
    n_chk++; if (edit_digit !== 2'd0) begin n_fail++; $display("FAIL wr_digit_wrap: got %0d exp 0", edit_digit); end
    press(4);
  endtask

  task automatic test_priority_hold;
    cur = {2'd0, 4'd8, 4'd1, 4'd5};
    press(2);
    btn = 5'b11000;
    @(negedge clk);
    n_chk++; if ({editing, set_time, set_alarm} !== 3'b000) begin n_fail++; $display("FAIL pr_cancel_enter: got %b exp 000", {editing, set_time, set_alarm}); end
    btn = '0;
    @(negedge clk);
    n_chk++; if ({editing, set_time} !== 2'b00) begin n_fail++; $display("FAIL pr_no_commit: got %b exp 00", {editing, set_time}); end
    press(2);
    btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    btn = '0;
    @(negedge clk);
    n_chk++; if (in_t !== {2'd1, 4'd8, 4'd1, 4'd5}) begin n_fail++; $display("FAIL pr_hold_inc: got %h exp 1815", in_t); end
    btn = 5'b00111;
    @(negedge clk);
    n_chk++; if ({edit_alarm, edit_digit} !== 3'b100) begin n_fail++; $display("FAIL pr_mode_wins: got %b exp 100", {edit_alarm, edit_digit}); end
    n_chk++; if (in_t !== {2'd0, 4'd0, 4'd3, 4'd5}) begin n_fail++; $display("FAIL pr_mode_load: got %h exp 0035", in_t); end
    btn = '0;
    @(negedge clk);
    press(4);
  endtask

  task automatic test_timeout;
    cur = {2'd1, 4'd0, 4'd1, 4'd0};
    press(2);
    repeat (28) @(negedge clk);
    n_chk++; if (editing !== 1'b1) begin n_fail++; $display("FAIL to_before: got %b exp 1", editing); end
    @(negedge clk);
    n_chk++; if ({editing, set_time, set_alarm} !== 3'b000) begin n_fail++; $display("FAIL to_expire: got %b exp 000", {editing, set_time, set_alarm}); end
  endtask

  task automatic test_reset_mid_edit;
    cur = {2'd1, 4'd2, 4'd3, 4'd4};
    press(2); press(0); press(1);
    n_chk++; if (in_t !== {2'd2, 4'd2, 4'd3, 4'd4}) begin n_fail++; $display("FAIL rs_pre: got %h exp 2234", in_t); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (in_t !== 14'd0) begin n_fail++; $display("FAIL rs_in: got %h exp 0", in_t); end
    n_chk++; if ({editing, edit_digit} !== 3'b000) begin n_fail++; $display("FAIL rs_flags: got %b exp 000", {editing, edit_digit}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    press(2);
    btn[3] = 1'b1;
    @(negedge clk);
    n_chk++; if (set_time !== 1'b1) begin n_fail++; $display("FAIL rs_commit_pre: got %b exp 1", set_time); end
    #1 reset = 1'b0;
    #1;
    n_chk++; if ({set_time, set_alarm} !== 2'b00) begin n_fail++; $display("FAIL rs_commit_abort: got %b exp 00", {set_time, set_alarm}); end
    btn = 5'b00100;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (editing !== 1'b0) begin n_fail++; $display("FAIL rs_held_btn: got %b exp 0", editing); end
    btn = '0;
    @(negedge clk);
    press(2);
    n_chk++; if (in_t !== {2'd1, 4'd2, 4'd3, 4'd4}) begin n_fail++; $display("FAIL rs_repress: got %h exp 1234", in_t); end
    press(2);
    n_chk++; if (in_t !== 14'd0) begin n_fail++; $display("FAIL rs_shadow_clr: got %h exp 0000", in_t); end
    press(4);
  endtask

  initial begin
    test_reset();
    test_time_set();
    test_alarm_set();
    test_hour_clamp();
    test_wrap();
    test_priority_hold();
    test_timeout();
    test_reset_mid_edit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Parameters
REQ-001 The block SHALL take parameter TIMEOUT, default 30, meaning the number of clk cycles with no button press before an edit is abandoned.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports btn_mode, btn_next, btn_inc, btn_enter and btn_cancel, each an input of 1 bit: level-sensitive synchronous button levels.
REQ-005 The block SHALL have ports cur_hour_msb (input, 2 bits), cur_hour_lsb (input, 4 bits), cur_min_msb (input, 4 bits) and cur_min_lsb (input, 4 bits): the live BCD clock time.
REQ-006 The block SHALL have outputs inhour_msb (2 bits), inhour_lsb (4 bits), inmin_msb (4 bits) and inmin_lsb (4 bits): the BCD value being edited or committed.
REQ-007 The block SHALL have outputs set_time and set_alarm, each 1 bit: single-cycle commit strobes.
REQ-008 The block SHALL have outputs editing (1 bit), edit_alarm (1 bit: 1 = alarm target, 0 = time target) and edit_digit (2 bits: 0 = hour_msb, 1 = hour_lsb, 2 = min_msb, 3 = min_lsb).

Function
REQ-009 The block SHALL detect the rising edge of each button using a registered previous level, so that a held button counts as exactly one press.
REQ-010 When several presses occur in the same cycle, the block SHALL act on only the highest-priority one: cancel > enter > mode > next > inc.
REQ-011 The block SHALL implement a state machine with states IDLE, EDIT_TIME, EDIT_ALARM and COMMIT.
REQ-012 On a mode press in IDLE, the block SHALL go to EDIT_TIME, load the edit buffer from the cur_* inputs in that same cycle, and set edit_digit to 0.
REQ-013 On a mode press in EDIT_TIME, the block SHALL go to EDIT_ALARM, load the edit buffer from the alarm shadow register, and set edit_digit to 0.
REQ-014 On a mode press in EDIT_ALARM, the block SHALL go to IDLE without committing.
REQ-015 On a next press, the block SHALL advance edit_digit by 1, wrapping from 3 to 0.
REQ-016 On an inc press, the block SHALL increment only the selected digit, using these wrap rules:
- hour_msb: 0→1→2→0
- hour_lsb: 0–9 wrap to 0, or 0–3 wrap to 0 when hour_msb = 2
- min_msb: 0–5 wrap to 0
- min_lsb: 0–9 wrap to 0
REQ-017 When hour_msb becomes 2 while hour_lsb > 3, the block SHALL force hour_lsb to 0 in the same cycle.
REQ-018 An increment SHALL never carry into a neighbouring digit.
REQ-019 On an enter press in either edit state, the block SHALL go to COMMIT.
REQ-020 In COMMIT, the block SHALL assert exactly one cycle of set_time (from EDIT_TIME) or set_alarm (from EDIT_ALARM), then return to IDLE.
REQ-021 A commit from EDIT_ALARM SHALL also write the edit buffer into the alarm shadow register.
REQ-022 The in* outputs SHALL equal the edit buffer whenever the block is not in reset.
REQ-023 The in* outputs SHALL be stable in the strobe cycle and SHALL hold the committed value in IDLE until the next edit begins.
REQ-024 On a cancel press in either edit state, the block SHALL go to IDLE with no strobe, and the in* outputs SHALL keep the edit buffer contents.
REQ-025 The block SHALL keep an inactivity counter that clears on any accepted press or state change and counts in the edit states only.
REQ-026 When the inactivity counter reaches TIMEOUT−1, the block SHALL go to IDLE on the next clock with no strobe.
REQ-027 The inactivity counter SHALL saturate and SHALL NOT wrap.
REQ-028 In IDLE and COMMIT, the block SHALL ignore every button except mode in IDLE.
REQ-029 set_time and set_alarm SHALL never be asserted in the same cycle.
REQ-030 editing SHALL be 1 exactly when the state is EDIT_TIME or EDIT_ALARM.
REQ-031 edit_alarm SHALL be 1 exactly in EDIT_ALARM.

Reset
REQ-032 When reset = 0, the block SHALL immediately, regardless of clk, set:
- the state to IDLE
- the edit buffer, the alarm shadow register and all in* outputs to 00:00
- set_time, set_alarm, editing, edit_alarm and edit_digit to 0
- the inactivity counter to 0
- the button edge registers to 0
REQ-033 Reset asserted during EDIT or COMMIT SHALL abort the operation with no strobe, including when it is asserted in the COMMIT cycle itself.
REQ-034 After reset deasserts, a button already held high SHALL NOT register a press until it is released and pressed again.

Verification
REQ-035 The bench SHALL cover time set: cur = 11:26; mode, inc, next, inc, enter → set_time high for exactly 1 cycle with in* = 22:26, then in* stays at 22:26 in IDLE.
REQ-036 The bench SHALL cover alarm set: mode, mode (buffer = 00:00), next, next, inc×3, next, inc×5, enter → set_alarm pulses once with 00:35; a later alarm edit reloads 00:35.
REQ-037 The bench SHALL cover the hour clamp: edit from 19:00; select hour_msb, inc → 20:00 (hour_lsb forced to 0); select hour_lsb, inc×4 → 23 then 20.
REQ-038 The bench SHALL cover wrap: on min_msb = 5, inc → 0 with no carry into hour; on digit 3, next → edit_digit = 0.
REQ-039 The bench SHALL cover priority and hold: enter and cancel in the same cycle → IDLE, no strobe; inc held high for 10 cycles → one increment.
REQ-040 The bench SHALL cover timeout and reset: with TIMEOUT = 30, no press for 30 cycles in EDIT_TIME → IDLE, no strobe; reset pulsed low mid-edit → all outputs 0 immediately.
